mem_lane_sequencer: RTL and testbench

//  Memory-stage access unit between the Execute-Mem buffer and the Mem-WriteBack buffer.

---
 rtl/mem_lane_sequencer.sv | 141 ++++++++++++++
 tb/tb_mem_lane_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer: serialises the three M-stage lane accesses onto one single-port data RAM
// and holds StallM until the vector access is complete. Optional: define LANE_COALESCE_EN.
module mem_lane_sequencer #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 19
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   MemWriteM,
  input  logic                   MemtoRegM,
  input  logic [ADDR_W-1:0]      A1M,
  input  logic [ADDR_W-1:0]      A2M,
  input  logic [ADDR_W-1:0]      A3M,
  input  logic [2:0][DATA_W-1:0] writeDataM,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic [2:0][DATA_W-1:0] RDM,
  output logic                   StallM
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    LAST = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state;
  logic                req;
  logic                coal_req;
  logic                is_store;
  logic                coal;
  logic [ADDR_W-1:0]   addr1;
  logic [ADDR_W-1:0]   addr2;
  logic [DATA_W-1:0]   data1;
  logic [DATA_W-1:0]   data2;
  logic [DATA_W-1:0]   stage0;
  logic [DATA_W-1:0]   stage1;

  // A simultaneous load+store request is handled as a store.
  assign req = MemWriteM | MemtoRegM;

`ifdef LANE_COALESCE_EN
  assign coal_req = (A1M == A2M) && (A2M == A3M);
`else
  assign coal_req = 1'b0;
`endif

  // Stall is raised in the detect cycle itself so the M stage never advances mid-access.
  always_comb begin
    StallM = 1'b1;
    case (state)
      IDLE:    StallM = req;
      DONE:    StallM = 1'b0;
      default: StallM = 1'b1;
    endcase
  end

  // Sequencer: RAM address/data are registered so each ACCk state presents lane k.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      RDM       <= '0;
      is_store  <= 1'b0;
      coal      <= 1'b0;
      addr1     <= '0;
      addr2     <= '0;
      data1     <= '0;
      data2     <= '0;
      stage0    <= '0;
      stage1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_store <= MemWriteM;
            coal     <= coal_req;
            addr1    <= A2M;
            addr2    <= A3M;
            data1    <= writeDataM[1];
            data2    <= writeDataM[2];
            ram_addr <= A1M;
            ram_we   <= MemWriteM;
            if (MemWriteM) begin
              ram_wdata <= coal_req ? writeDataM[2] : writeDataM[0];
            end
            state <= ACC0;
          end
        end
        ACC0: begin
          if (coal) begin
            ram_we <= 1'b0;
            state  <= is_store ? DONE : LAST;
          end else begin
            ram_addr <= addr1;
            if (is_store) begin
              ram_wdata <= data1;
            end
            state <= ACC1;
          end
        end
        ACC1: begin
          stage0   <= ram_rdata;
          ram_addr <= addr2;
          if (is_store) begin
            ram_wdata <= data2;
          end
          state <= ACC2;
        end
        ACC2: begin
          stage1 <= ram_rdata;
          ram_we <= 1'b0;
          state  <= is_store ? DONE : LAST;
        end
        LAST: begin
          // Lane 2 word arrives this cycle; commit the whole vector at once.
          if (coal) begin
            RDM <= {ram_rdata, ram_rdata, ram_rdata};
          end else begin
            RDM <= {ram_rdata, stage1, stage0};
          end
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// tb_mem_lane_sequencer: randomized and directed checks of mem_lane_sequencer against a
// transaction-level memory model.
module tb_mem_lane_sequencer;

`ifdef LANE_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             MemWriteM;
  logic             MemtoRegM;
  logic [18:0]      A1M;
  logic [18:0]      A2M;
  logic [18:0]      A3M;
  logic [2:0][17:0] writeDataM;
  logic [17:0]      ram_rdata;
  logic [18:0]      ram_addr;
  logic             ram_we;
  logic [17:0]      ram_wdata;
  logic [2:0][17:0] RDM;
  logic             StallM;

  int total = 0;
  int bad   = 0;

  logic [17:0] ram     [logic [18:0]];
  logic [17:0] ref_mem [logic [18:0]];
  logic [53:0] rdm_model;

  mem_lane_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemWriteM (MemWriteM),
    .MemtoRegM (MemtoRegM),
    .A1M       (A1M),
    .A2M       (A2M),
    .A3M       (A3M),
    .writeDataM(writeDataM),
    .ram_rdata (ram_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .RDM       (RDM),
    .StallM    (StallM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [17:0] ram_rd(input logic [18:0] a);
    return ram.exists(a) ? ram[a] : 18'h0;
  endfunction

  function automatic logic [17:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 18'h0;
  endfunction

  // Single-port RAM, one-cycle read latency.
  always @(posedge CLK) begin
    ram_rdata <= ram_rd(ram_addr);
    if (ram_we) ram[ram_addr] = ram_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [18:0] a, input logic [17:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      MemWriteM = 1'b0;
      MemtoRegM = 1'b0;
      #1;
      check("idle_stall", 64'(StallM), 64'(0));
      check("idle_we", 64'(ram_we), 64'(0));
      check("idle_rdm", 64'(RDM), 64'(rdm_model));
    end
  endtask

  // One vector access: drives the request, watches the stall window, then updates the model.
  task automatic do_op(input logic wr, input logic rd,
                       input logic [18:0] a0, input logic [18:0] a1, input logic [18:0] a2,
                       input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2);
    logic [18:0] ea [3];
    logic [17:0] ed [3];
    logic [18:0] oa [4];
    logic        ow [4];
    logic [17:0] od [4];
    logic        st;
    int          nacc;
    int          exp_stall;
    int          n;
    st = wr;
    if (COAL && a0 == a1 && a1 == a2) begin
      nacc  = 1;
      ea[0] = a0;
      ed[0] = d2;
    end else begin
      nacc = 3;
      ea   = '{a0, a1, a2};
      ed   = '{d0, d1, d2};
    end
    exp_stall = 1 + nacc + (st ? 0 : 1);
    @(negedge CLK);
    MemWriteM  = wr;
    MemtoRegM  = rd;
    A1M        = a0;
    A2M        = a1;
    A3M        = a2;
    writeDataM = {d2, d1, d0};
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!StallM) break;
      check("rdm_hold", 64'(RDM), 64'(rdm_model));
      if (n >= 1 && n <= 3) begin
        oa[n] = ram_addr;
        ow[n] = ram_we;
        od[n] = ram_wdata;
      end
      n++;
      @(negedge CLK);
    end
    check("stall_cycles", 64'(n), 64'(exp_stall));
    for (int k = 0; k < nacc; k++) begin
      check("acc_addr", 64'(oa[k+1]), 64'(ea[k]));
      check("acc_we", 64'(ow[k+1]), 64'(st));
      if (st) check("acc_wdata", 64'(od[k+1]), 64'(ed[k]));
    end
    if (st) begin
      ref_mem[a0] = d0;
      ref_mem[a1] = d1;
      ref_mem[a2] = d2;
    end else begin
      rdm_model = {ref_rd(a2), ref_rd(a1), ref_rd(a0)};
    end
    check("rdm_done", 64'(RDM), 64'(rdm_model));
    check("we_done", 64'(ram_we), 64'(0));
  endtask

  function automatic logic [18:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 19'h7FFFF : 19'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] a0, a1, a2;
    int          op;
    RST        = 1'b1;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    A1M        = '0;
    A2M        = '0;
    A3M        = '0;
    writeDataM = '0;
    rdm_model  = '0;
    #1;
    check("rst_addr", 64'(ram_addr), 64'(0));
    check("rst_we", 64'(ram_we), 64'(0));
    check("rst_wdata", 64'(ram_wdata), 64'(0));
    check("rst_rdm", 64'(RDM), 64'(0));
    check("rst_stall", 64'(StallM), 64'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    do_idle(2);

    // Directed load and store.
    preload(19'h00010, 18'h1AAAA);
    preload(19'h00011, 18'h2BBBB);
    preload(19'h00012, 18'h3CCCC);
    do_op(1'b0, 1'b1, 19'h00010, 19'h00011, 19'h00012, 18'h0, 18'h0, 18'h0);
    check("load_vec", 64'(RDM), 64'({18'h3CCCC, 18'h2BBBB, 18'h1AAAA}));
    do_idle(1);
    do_op(1'b1, 1'b0, 19'h7FFFF, 19'h00000, 19'h00001, 18'h1, 18'h2, 18'h3);
    do_idle(1);
    do_op(1'b1, 1'b1, 19'h00010, 19'h00011, 19'h00012, 18'h0AAA1, 18'h0BBB2, 18'h0CCC3);
    // Back-to-back loads, no idle gap.
    do_op(1'b0, 1'b1, 19'h7FFFF, 19'h00000, 19'h00001, 18'h0, 18'h0, 18'h0);
    do_op(1'b0, 1'b1, 19'h00010, 19'h00011, 19'h00012, 18'h0, 18'h0, 18'h0);
    check("b2b_vec", 64'(RDM), 64'({18'h0CCC3, 18'h0BBB2, 18'h0AAA1}));
    // Fully coalescable addresses.
    preload(19'h00100, 18'h0F0F0);
    do_op(1'b0, 1'b1, 19'h00100, 19'h00100, 19'h00100, 18'h0, 18'h0, 18'h0);
    do_op(1'b1, 1'b0, 19'h00100, 19'h00100, 19'h00100, 18'h11111, 18'h22222, 18'h33333);
    do_op(1'b0, 1'b1, 19'h00100, 19'h00100, 19'h00100, 18'h0, 18'h0, 18'h0);
    do_idle(1);

    // Reset during ACC1 of a load.
    @(negedge CLK);
    MemWriteM = 1'b0; MemtoRegM = 1'b1;
    A1M = 19'h00010; A2M = 19'h00011; A3M = 19'h00012;
    repeat (2) @(negedge CLK);
    RST = 1'b1; MemtoRegM = 1'b0;
    #1;
    rdm_model = '0;
    check("arst_we", 64'(ram_we), 64'(0));
    check("arst_rdm", 64'(RDM), 64'(0));
    check("arst_stall", 64'(StallM), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    do_op(1'b0, 1'b1, 19'h00012, 19'h00011, 19'h00010, 18'h0, 18'h0, 18'h0);

    // Reset during ACC1 of a store: only the lane-0 write has been issued.
    @(negedge CLK);
    MemWriteM = 1'b1; MemtoRegM = 1'b0;
    A1M = 19'h00020; A2M = 19'h00021; A3M = 19'h00022;
    writeDataM = {18'h3DDDD, 18'h2EEEE, 18'h1FFFF};
    repeat (2) @(negedge CLK);
    RST = 1'b1; MemWriteM = 1'b0;
    #1;
    rdm_model = '0;
    check("arst_st_we", 64'(ram_we), 64'(0));
    check("arst_st_stall", 64'(StallM), 64'(0));
    ref_mem[19'h00020] = 18'h1FFFF;
    @(negedge CLK);
    RST = 1'b0;
    do_op(1'b0, 1'b1, 19'h00020, 19'h00021, 19'h00022, 18'h0, 18'h0, 18'h0);

    // Randomized mix of loads, stores and combined requests.
    for (int t = 0; t < 60; t++) begin
      a0 = rand_addr();
      a1 = rand_addr();
      a2 = rand_addr();
      if ($urandom_range(0, 3) == 0) begin
        a1 = a0;
        a2 = a0;
      end
      op = int'($urandom_range(0, 2));
      do_op(op != 0, op != 1, a0, a1, a2,
            18'($urandom), 18'($urandom), 18'($urandom));
      do_idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
